// File: rtl/clk_gate_sequencer_if.sv
// Request/status bundle between requesters and the clock-gate sequencer.
// The requester side drives desired enables and test mode; the sequencer returns gate enables and status.
interface clk_gate_sequencer_if #(
    parameter int NumDomains = 4
);
    logic [NumDomains-1:0] req_en_i;
    logic                  test_mode_i;
    logic [NumDomains-1:0] clk_en_o;
    logic [NumDomains-1:0] done_o;
    logic                  busy_o;

    modport master (
        output req_en_i,
        output test_mode_i,
        input  clk_en_o,
        input  done_o,
        input  busy_o
    );

    modport slave (
        input  req_en_i,
        input  test_mode_i,
        output clk_en_o,
        output done_o,
        output busy_o
    );
endinterface

// File: rtl/clk_gate_sequencer.sv
// Serialises clock-gate enable changes one domain at a time, with a guard interval after each toggle.
//   state | meaning
//   IDLE  | look for pending changes, issue one toggle (round-robin from rr_ptr)
//   GUARD | count down the guard interval, then one done cycle before returning to IDLE
module clk_gate_sequencer #(
    parameter int                    NumDomains  = 4,
    parameter int                    GuardCycles = 8,
    parameter logic [NumDomains-1:0] ResetEnable = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    clk_gate_sequencer_if.slave  bus
);

    localparam int SelW = (NumDomains > 1) ? $clog2(NumDomains) : 1;
    localparam int CntW = $clog2(GuardCycles + 1);
    localparam logic [CntW-1:0] GuardInit = CntW'(GuardCycles - 1);

    if (GuardCycles < 1) begin : g_guard_check
        $error("clk_gate_sequencer: GuardCycles must be >= 1");
    end
    if (NumDomains < 1 || NumDomains > 32) begin : g_dom_check
        $error("clk_gate_sequencer: NumDomains must be 1..32");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GUARD = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [NumDomains-1:0] en_q, en_d;
    logic [NumDomains-1:0] done_q, done_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [SelW-1:0]       sel_q, sel_d;
    logic [SelW-1:0]       rr_ptr_q, rr_ptr_d;

    logic [NumDomains-1:0] pending;
    logic [SelW-1:0]       pick;
    logic [SelW-1:0]       cand;
    logic                  found;

    assign pending = bus.req_en_i ^ en_q;

    // First pending domain at or after rr_ptr, wrapping at NumDomains-1.
    always_comb begin : pick_search
        int c;
        c     = 0;
        cand  = '0;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NumDomains; i++) begin
            c = int'(rr_ptr_q) + i;
            if (c >= NumDomains) begin
                c = c - NumDomains;
            end
            cand = SelW'(c);
            if (!found && pending[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            en_q     <= ResetEnable;
            done_q   <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        done_d   = '0;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    en_d[pick] = ~en_q[pick];
                    sel_d      = pick;
                    cnt_d      = GuardInit;
                    state_d    = GUARD;
                end
            end
            GUARD: begin
                // done_q is only ever set from GUARD, so it marks the final done cycle.
                if (done_q != '0) begin
                    state_d  = IDLE;
                    rr_ptr_d = (sel_q == SelW'(NumDomains - 1)) ? '0 : sel_q + 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    done_d[sel_q] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.clk_en_o = en_q | {NumDomains{bus.test_mode_i}};
    assign bus.done_o   = done_q;
    assign bus.busy_o   = (state_q == GUARD) || (pending != '0);

endmodule

// File: tb/tb_clk_gate_sequencer.sv
// Directed bench for clk_gate_sequencer: reset values, toggle/guard timing, round-robin order,
// withdrawn requests, test mode and reset during the guard interval.
module tb_clk_gate_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n;
    logic rst_b_n;

    clk_gate_sequencer_if #(.NumDomains(4)) bus_a ();
    clk_gate_sequencer_if #(.NumDomains(4)) bus_b ();

    clk_gate_sequencer #(
        .NumDomains (4),
        .GuardCycles(8),
        .ResetEnable(4'b0101)
    ) u_dut_a (
        .clk_i (clk),
        .rst_ni(rst_a_n),
        .bus   (bus_a.slave)
    );

    clk_gate_sequencer #(
        .NumDomains (4),
        .GuardCycles(8),
        .ResetEnable(4'b0000)
    ) u_dut_b (
        .clk_i (clk),
        .rst_ni(rst_b_n),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic [3:0] req;
        logic       tm;
        int         n;
        logic [3:0] en;
        logic [3:0] done;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   n_checks   = 0;
    int   n_failures = 0;

    function automatic vec_t mk(logic [3:0] req, logic tm, int n,
                                logic [3:0] en, logic [3:0] done, logic busy);
        vec_t v;
        v.req = req; v.tm = tm; v.n = n; v.en = en; v.done = done; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_b(input string tag, input logic [3:0] en, input logic [3:0] done,
                           input logic busy);
        check({tag, " clk_en"}, 32'(bus_b.clk_en_o), 32'(en));
        check({tag, " done"},   32'(bus_b.done_o),   32'(done));
        check({tag, " busy"},   32'(bus_b.busy_o),   32'(busy));
    endtask

    task automatic check_a(input string tag, input logic [3:0] en, input logic [3:0] done,
                           input logic busy);
        check({tag, " clk_en"}, 32'(bus_a.clk_en_o), 32'(en));
        check({tag, " done"},   32'(bus_a.done_o),   32'(done));
        check({tag, " busy"},   32'(bus_a.busy_o),   32'(busy));
    endtask

    initial begin
        // test mode with en_q=0000, then single toggle timing
        vecs.push_back(mk(4'b0000, 1'b1, 1, 4'b1111, 4'b0000, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b0, 1, 4'b0000, 4'b0000, 1'b1));
        vecs.push_back(mk(4'b0001, 1'b0, 8, 4'b0001, 4'b0000, 1'b1));
        vecs.push_back(mk(4'b0001, 1'b0, 1, 4'b0001, 4'b0001, 1'b1));
        vecs.push_back(mk(4'b0001, 1'b0, 2, 4'b0001, 4'b0000, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b1, 1, 4'b1111, 4'b0000, 1'b0));
        vecs.push_back(mk(4'b0001, 1'b0, 1, 4'b0001, 4'b0000, 1'b0));
        // domain 1 requested, withdrawn during GUARD, then toggled back
        vecs.push_back(mk(4'b0011, 1'b0, 1, 4'b0001, 4'b0000, 1'b1));
        vecs.push_back(mk(4'b0011, 1'b0, 1, 4'b0011, 4'b0000, 1'b1));
        vecs.push_back(mk(4'b0001, 1'b0, 7, 4'b0011, 4'b0000, 1'b1));
        vecs.push_back(mk(4'b0001, 1'b0, 1, 4'b0011, 4'b0010, 1'b1));
        vecs.push_back(mk(4'b0001, 1'b0, 1, 4'b0011, 4'b0000, 1'b1));
        vecs.push_back(mk(4'b0001, 1'b0, 8, 4'b0001, 4'b0000, 1'b1));
        vecs.push_back(mk(4'b0001, 1'b0, 1, 4'b0001, 4'b0010, 1'b1));
        vecs.push_back(mk(4'b0001, 1'b0, 2, 4'b0001, 4'b0000, 1'b0));
        // rr_ptr=2, pending {0,3}: domain 3 first, then domain 0
        vecs.push_back(mk(4'b1000, 1'b0, 1, 4'b0001, 4'b0000, 1'b1));
        vecs.push_back(mk(4'b1000, 1'b0, 8, 4'b1001, 4'b0000, 1'b1));
        vecs.push_back(mk(4'b1000, 1'b0, 1, 4'b1001, 4'b1000, 1'b1));
        vecs.push_back(mk(4'b1000, 1'b0, 1, 4'b1001, 4'b0000, 1'b1));
        vecs.push_back(mk(4'b1000, 1'b0, 8, 4'b1000, 4'b0000, 1'b1));
        vecs.push_back(mk(4'b1000, 1'b0, 1, 4'b1000, 4'b0001, 1'b1));
        vecs.push_back(mk(4'b1000, 1'b0, 2, 4'b1000, 4'b0000, 1'b0));

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        bus_a.req_en_i    = 4'b0101;
        bus_a.test_mode_i = 1'b0;
        bus_b.req_en_i    = 4'b0000;
        bus_b.test_mode_i = 1'b0;
        step();
        step();
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        #1;
        check_a("reset_a", 4'b0101, 4'b0000, 1'b0);
        check_b("reset_b", 4'b0000, 4'b0000, 1'b0);
        step();

        for (int i = 0; i < 20; i++) begin
            check_a($sformatf("hold_a c%0d", i), 4'b0101, 4'b0000, 1'b0);
            step();
        end

        for (int v = 0; v < vecs.size(); v++) begin
            for (int j = 0; j < vecs[v].n; j++) begin
                bus_b.req_en_i    = vecs[v].req;
                bus_b.test_mode_i = vecs[v].tm;
                #1;
                check_b($sformatf("vec%0d.%0d", v, j), vecs[v].en, vecs[v].done, vecs[v].busy);
                step();
            end
        end
        bus_b.test_mode_i = 1'b0;

        // all four domains requested at once from a fresh reset
        rst_b_n = 1'b0;
        step();
        rst_b_n = 1'b1;
        bus_b.req_en_i = 4'b1111;
        for (int c = 0; c < 42; c++) begin
            logic [3:0] exp_en;
            logic [3:0] exp_done;
            exp_en   = 4'b0000;
            exp_done = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                if (c >= 1 + 10 * k) exp_en[k] = 1'b1;
                if (c == 9 + 10 * k) exp_done[k] = 1'b1;
            end
            #1;
            check_b($sformatf("all c%0d", c), exp_en, exp_done, c < 40);
            step();
        end

        // reset during GUARD on the ResetEnable=0101 instance
        bus_a.req_en_i = 4'b0111;
        #1;
        check_a("rg c0", 4'b0101, 4'b0000, 1'b1);
        step();
        check_a("rg c1", 4'b0111, 4'b0000, 1'b1);
        step();
        step();
        step();
        rst_a_n = 1'b0;
        bus_a.req_en_i = 4'b0101;
        step();
        rst_a_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            check_a($sformatf("post_rst c%0d", c), 4'b0101, 4'b0000, 1'b0);
            step();
        end
        bus_a.test_mode_i = 1'b1;
        #1;
        check_a("tm_a", 4'b1111, 4'b0000, 1'b0);
        bus_a.test_mode_i = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
